// File: rtl/seg_display_arbiter.sv
// Two-requester arbiter for the 8-digit multiplexed 7-segment display.
// Owns the scan scheduler (prescaler, digit select, common decode, BCD decode)
// and hands the display over only at frame boundaries so frames never mix sources.
module seg_display_arbiter #(
  parameter int SCAN_DIV = 4,  // cycles per digit slot, 1..255
  parameter int MIN_HOLD = 2   // frames kept before yielding to a waiting requester
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_A,
  input  logic        REQ_B,
  input  logic [31:0] DATA_A_IN,
  input  logic [31:0] DATA_B_IN,
  output logic        GNT_A,
  output logic        GNT_B,
  output logic [2:0]  SEL,
  output logic [6:0]  SEG7,
  output logic [7:0]  SEG_COM
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, SWITCH} state_t;

  localparam logic [7:0] PD = 8'(SCAN_DIV - 1);
  localparam logic [7:0] MH = 8'(MIN_HOLD);

  state_t      state, state_n;
  logic [7:0]  presc, presc_n;
  logic [7:0]  fcnt, fcnt_n, fc_inc;
  logic [2:0]  sel_n;
  logic [31:0] shadow, shadow_n;
  logic        last, last_n;        // 0 = A held it last, 1 = B
  logic        enter_a, enter_b;
  logic        tick, boundary;
  logic        own_req, oth_req;
  logic [31:0] own_data;
  logic        gnt_a_n, gnt_b_n;
  logic [7:0]  com_n;
  logic [6:0]  seg_n;

  function automatic logic [6:0] bcd7(input logic [3:0] d);
    case (d)
      4'd0:    bcd7 = 7'b1111110;
      4'd1:    bcd7 = 7'b0110000;
      4'd2:    bcd7 = 7'b1101101;
      4'd3:    bcd7 = 7'b1111001;
      4'd4:    bcd7 = 7'b0110011;
      4'd5:    bcd7 = 7'b1011011;
      4'd6:    bcd7 = 7'b1011111;
      4'd7:    bcd7 = 7'b1110010;
      4'd8:    bcd7 = 7'b1111111;
      4'd9:    bcd7 = 7'b1110011;
      default: bcd7 = 7'b1111110;  // non-BCD nibbles render as 0
    endcase
  endfunction

  assign tick     = (presc == PD);
  assign boundary = tick && (SEL == 3'd7);
  assign own_req  = (state == GRANT_B) ? REQ_B : REQ_A;
  assign oth_req  = (state == GRANT_B) ? REQ_A : REQ_B;
  assign own_data = (state == GRANT_B) ? DATA_B_IN : DATA_A_IN;
  assign fc_inc   = (fcnt >= MH) ? MH : fcnt + 8'd1;

  // State and scan registers, plus registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      presc   <= '0;
      fcnt    <= '0;
      shadow  <= '0;
      last    <= 1'b1;
      SEL     <= '0;
      GNT_A   <= 1'b0;
      GNT_B   <= 1'b0;
      SEG_COM <= 8'hFF;
      SEG7    <= '0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      fcnt    <= fcnt_n;
      shadow  <= shadow_n;
      last    <= last_n;
      SEL     <= sel_n;
      GNT_A   <= gnt_a_n;
      GNT_B   <= gnt_b_n;
      SEG_COM <= com_n;
      SEG7    <= seg_n;
    end
  end

  // Next-state: arbitration, scan counters, shadow capture
  always_comb begin
    state_n  = state;
    presc_n  = presc;
    fcnt_n   = fcnt;
    shadow_n = shadow;
    last_n   = last;
    sel_n    = SEL;
    enter_a  = 1'b0;
    enter_b  = 1'b0;
    case (state)
      IDLE: begin
        presc_n = '0;
        sel_n   = '0;
        if (REQ_A && (!REQ_B || last)) enter_a = 1'b1;
        else if (REQ_B)                enter_b = 1'b1;
      end
      GRANT_A, GRANT_B: begin
        presc_n = tick ? 8'd0 : presc + 8'd1;
        if (tick) sel_n = SEL + 3'd1;
        if (boundary) begin
          fcnt_n = fc_inc;
          if (!own_req)                      state_n = oth_req ? SWITCH : IDLE;
          else if (oth_req && fc_inc >= MH)  state_n = SWITCH;
          else                               shadow_n = own_data;
        end
      end
      SWITCH: begin
        sel_n   = '0;
        presc_n = presc + 8'd1;
        if (tick) begin
          presc_n = '0;
          // prefer the waiting side, fall back to the previous owner
          if (last ? REQ_A : REQ_B) begin
            enter_a = last;
            enter_b = !last;
          end else if (last ? REQ_B : REQ_A) begin
            enter_a = !last;
            enter_b = last;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (enter_a || enter_b) begin
      state_n  = enter_a ? GRANT_A : GRANT_B;
      presc_n  = '0;
      sel_n    = '0;
      fcnt_n   = '0;
      shadow_n = enter_a ? DATA_A_IN : DATA_B_IN;
      last_n   = enter_b;
    end
  end

  // Output decode from next-state values so outputs align with SEL
  always_comb begin
    gnt_a_n = (state_n == GRANT_A);
    gnt_b_n = (state_n == GRANT_B);
    com_n   = 8'hFF;
    seg_n   = '0;
    if (gnt_a_n || gnt_b_n) begin
      com_n = ~(8'h80 >> sel_n);
      seg_n = bcd7(shadow_n[{sel_n, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter (SCAN_DIV=4, MIN_HOLD=2 plus a MIN_HOLD=0 copy).
module tb_seg_display_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_A, REQ_B, r0_a, r0_b;
  logic [31:0] DATA_A_IN, DATA_B_IN;
  logic        GNT_A, GNT_B, g0_a, g0_b;
  logic [2:0]  SEL, sel0;
  logic [6:0]  SEG7, seg0;
  logic [7:0]  SEG_COM, com0;

  int checks = 0;
  int errors = 0;

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1110011};

  always #5 CLK = ~CLK;

  seg_display_arbiter #(.SCAN_DIV(4), .MIN_HOLD(2)) dut (
    .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .SEL(SEL), .SEG7(SEG7), .SEG_COM(SEG_COM));

  seg_display_arbiter #(.SCAN_DIV(4), .MIN_HOLD(0)) dut0 (
    .CLK(CLK), .RST(RST), .REQ_A(r0_a), .REQ_B(r0_b),
    .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN),
    .GNT_A(g0_a), .GNT_B(g0_b), .SEL(sel0), .SEG7(seg0), .SEG_COM(com0));

  // advance to the first negedge of digit slot k (bounded)
  task automatic goto_slot(input int k);
    int n = 0;
    while (SEL == 3'(k) && n < 200) begin @(negedge CLK); n++; end
    while (SEL != 3'(k) && n < 200) begin @(negedge CLK); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL goto_slot%0d timeout SEL=%0d", k, SEL); end
  endtask

  task automatic test_reset;
    RST = 1'b1; REQ_A = 0; REQ_B = 0; r0_a = 0; r0_b = 0;
    DATA_A_IN = '0; DATA_B_IN = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({GNT_A, GNT_B, SEL, SEG_COM, SEG7} !== {2'b00, 3'd0, 8'hFF, 7'd0}) begin
      errors++; $display("FAIL reset_vals got gnt=%b%b sel=%0d com=%h seg=%b", GNT_A, GNT_B, SEL, SEG_COM, SEG7);
    end
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    checks++;
    if (SEG_COM !== 8'hFF || SEL !== 3'd0 || GNT_A !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset com=%h sel=%0d exp FF/0", SEG_COM, SEL);
    end
  endtask

  task automatic test_single;
    logic [7:0] ec;
    DATA_A_IN = 32'h76543210; REQ_A = 1'b1;
    @(negedge CLK);
    checks++;
    if (GNT_A !== 1'b1 || GNT_B !== 1'b0) begin
      errors++; $display("FAIL grant_latency gnt=%b%b exp 10", GNT_A, GNT_B);
    end
    for (int k = 0; k < 8; k++) begin
      ec = 8'hFF ^ (8'h80 >> k);
      checks++;
      if (SEL !== 3'(k) || SEG_COM !== ec || SEG7 !== pat[k]) begin
        errors++; $display("FAIL scan_digit%0d sel=%0d com=%b seg=%b exp com=%b seg=%b", k, SEL, SEG_COM, SEG7, ec, pat[k]);
      end
      repeat (4) @(negedge CLK);
    end
    checks++;
    if (SEL !== 3'd0 || GNT_A !== 1'b1) begin
      errors++; $display("FAIL frame_wrap sel=%0d gnt=%b exp 0/1", SEL, GNT_A);
    end
  endtask

  task automatic test_coherence;
    DATA_A_IN = 32'h0;
    goto_slot(0);
    goto_slot(1);
    checks++;
    if (SEG7 !== 7'b1111110) begin errors++; $display("FAIL new_frame_load seg=%b exp 1111110", SEG7); end
    goto_slot(4);
    DATA_A_IN = 32'h99999999;
    for (int k = 4; k < 8; k++) begin
      if (k != 4) goto_slot(k);
      checks++;
      if (SEG7 !== 7'b1111110) begin errors++; $display("FAIL coherent_digit%0d seg=%b exp 1111110", k, SEG7); end
    end
    goto_slot(0);
    checks++;
    if (SEG7 !== 7'b1110011) begin errors++; $display("FAIL next_frame_d0 seg=%b exp 1110011", SEG7); end
    goto_slot(3);
    checks++;
    if (SEG7 !== 7'b1110011) begin errors++; $display("FAIL next_frame_d3 seg=%b exp 1110011", SEG7); end
    DATA_A_IN = 32'hFEDCBA0C;
    goto_slot(0);
    checks++;
    if (SEG7 !== 7'b1111110) begin errors++; $display("FAIL nibble_C seg=%b exp 1111110", SEG7); end
    goto_slot(7);
    checks++;
    if (SEG7 !== 7'b1111110) begin errors++; $display("FAIL nibble_F seg=%b exp 1111110", SEG7); end
  endtask

  task automatic test_release_a;
    goto_slot(3);
    REQ_A = 1'b0;
    goto_slot(5);
    checks++;
    if (GNT_A !== 1'b1) begin errors++; $display("FAIL hold_midframe gnt=%b exp 1", GNT_A); end
    goto_slot(7);
    repeat (3) @(negedge CLK);
    checks++;
    if (GNT_A !== 1'b1 || SEL !== 3'd7) begin errors++; $display("FAIL hold_last_slot gnt=%b sel=%0d", GNT_A, SEL); end
    @(negedge CLK);
    checks++;
    if (GNT_A !== 1'b0 || SEG_COM !== 8'hFF || SEL !== 3'd0 || SEG7 !== 7'd0) begin
      errors++; $display("FAIL release_idle gnt=%b com=%h sel=%0d seg=%b", GNT_A, SEG_COM, SEL, SEG7);
    end
  endtask

  task automatic test_reset_mid;
    REQ_A = 1'b1;
    repeat (6) @(negedge CLK);
    checks++;
    if (GNT_A !== 1'b1 || SEL !== 3'd1) begin errors++; $display("FAIL pre_reset gnt=%b sel=%0d exp 1/1", GNT_A, SEL); end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({GNT_A, GNT_B, SEL, SEG_COM, SEG7} !== {2'b00, 3'd0, 8'hFF, 7'd0}) begin
      errors++; $display("FAIL async_reset gnt=%b%b sel=%0d com=%h seg=%b", GNT_A, GNT_B, SEL, SEG_COM, SEG7);
    end
  endtask

  task automatic test_tie_fairness;
    DATA_A_IN = 32'h11111111; DATA_B_IN = 32'h22222222;
    REQ_A = 1'b1; REQ_B = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (GNT_A !== 1'b1 || GNT_B !== 1'b0 || SEG7 !== 7'b0110000) begin
      errors++; $display("FAIL tie_first gnt=%b%b seg=%b exp 10/0110000", GNT_A, GNT_B, SEG7);
    end
    repeat (63) @(negedge CLK);
    checks++;
    if (GNT_A !== 1'b1 || SEL !== 3'd7) begin errors++; $display("FAIL hold_two_frames gnt=%b sel=%0d", GNT_A, SEL); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (GNT_A !== 1'b0 || GNT_B !== 1'b0 || SEG_COM !== 8'hFF || SEG7 !== 7'd0 || SEL !== 3'd0) begin
        errors++; $display("FAIL switch_blank%0d gnt=%b%b com=%h seg=%b sel=%0d", i, GNT_A, GNT_B, SEG_COM, SEG7, SEL);
      end
    end
    @(negedge CLK);
    checks++;
    if (GNT_B !== 1'b1 || GNT_A !== 1'b0 || SEL !== 3'd0 || SEG_COM !== 8'h7F || SEG7 !== 7'b1101101) begin
      errors++; $display("FAIL grant_b gnt=%b%b sel=%0d com=%h seg=%b", GNT_A, GNT_B, SEL, SEG_COM, SEG7);
    end
  endtask

  task automatic test_release_b;
    REQ_A = 1'b0;
    goto_slot(3);
    REQ_B = 1'b0;
    goto_slot(7);
    repeat (3) @(negedge CLK);
    checks++;
    if (GNT_B !== 1'b1) begin errors++; $display("FAIL b_hold gnt_b=%b exp 1", GNT_B); end
    @(negedge CLK);
    checks++;
    if (GNT_B !== 1'b0 || SEG_COM !== 8'hFF) begin errors++; $display("FAIL b_release gnt_b=%b com=%h", GNT_B, SEG_COM); end
  endtask

  task automatic test_switch_drop;
    REQ_A = 1'b1; REQ_B = 1'b1;
    @(negedge CLK);
    checks++;
    if (GNT_A !== 1'b1) begin errors++; $display("FAIL tie_after_b gnt_a=%b exp 1", GNT_A); end
    repeat (64) @(negedge CLK);
    REQ_B = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (GNT_A !== 1'b0 || GNT_B !== 1'b0) begin errors++; $display("FAIL in_switch gnt=%b%b exp 00", GNT_A, GNT_B); end
    @(negedge CLK);
    checks++;
    if (GNT_A !== 1'b1 || GNT_B !== 1'b0 || SEG_COM !== 8'h7F) begin
      errors++; $display("FAIL regrant_prev gnt=%b%b com=%h", GNT_A, GNT_B, SEG_COM);
    end
    REQ_A = 1'b0;
    repeat (33) @(negedge CLK);
    checks++;
    if (GNT_A !== 1'b0 || SEG_COM !== 8'hFF) begin errors++; $display("FAIL idle_after_regrant gnt=%b com=%h", GNT_A, SEG_COM); end
  endtask

  task automatic test_min_hold0;
    r0_a = 1'b1; r0_b = 1'b1;
    @(negedge CLK);
    checks++;
    if (g0_a !== 1'b1 || g0_b !== 1'b0) begin errors++; $display("FAIL mh0_first gnt=%b%b exp 10", g0_a, g0_b); end
    repeat (31) @(negedge CLK);
    checks++;
    if (g0_a !== 1'b1) begin errors++; $display("FAIL mh0_frame_a gnt_a=%b exp 1", g0_a); end
    @(negedge CLK);
    checks++;
    if (g0_a !== 1'b0 || g0_b !== 1'b0 || com0 !== 8'hFF) begin errors++; $display("FAIL mh0_switch1 gnt=%b%b", g0_a, g0_b); end
    repeat (4) @(negedge CLK);
    checks++;
    if (g0_b !== 1'b1 || g0_a !== 1'b0 || sel0 !== 3'd0) begin errors++; $display("FAIL mh0_to_b gnt=%b%b sel=%0d", g0_a, g0_b, sel0); end
    repeat (32) @(negedge CLK);
    checks++;
    if (g0_a !== 1'b0 || g0_b !== 1'b0) begin errors++; $display("FAIL mh0_switch2 gnt=%b%b", g0_a, g0_b); end
    repeat (4) @(negedge CLK);
    checks++;
    if (g0_a !== 1'b1 || g0_b !== 1'b0 || seg0 !== 7'b1111110) begin
      errors++; $display("FAIL mh0_back_to_a gnt=%b%b seg=%b exp 10/1111110", g0_a, g0_b, seg0);
    end
    r0_a = 1'b0; r0_b = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_coherence;
    test_release_a;
    test_reset_mid;
    test_tie_fairness;
    test_release_b;
    test_switch_drop;
    DATA_A_IN = 32'h0;
    test_min_hold0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
